// File: rtl/train_sample_feeder.sv
// Training sample feeder.
//
// Holds DEPTH training samples (x1, x2, x3, target; 128 bits each, treated as opaque words).
// It presents them one at a time to a neural-network block for EPOCHS full passes.
// The network signals the end of an iteration by wrapping its 3-bit ctrl counter from 7 to 0.
// Each such wrap advances the feeder to the next sample.
//
// Optional feature: define FEEDER_WATCHDOG_EN to add a watchdog.
//   - It adds the wd_err output.
//   - It aborts a run when PRESENT sees no iteration complete for WD_LIMIT cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_addr      sample slot write strobe / slot index (honoured in IDLE and DONE only)
//   wr_x1..wr_target    sample words written to slot wr_addr
//   start               begin (or restart) a training run
//   ctrl                network iteration counter
//   x1, x2, x3          sample presented to the network
//   target_out          target presented to the network
//   set                 one-cycle weight-initialise pulse
//   busy                run in progress (INIT or PRESENT)
//   done                run finished, sticky until start or reset
//   sample_idx          slot currently presented
//   epoch_cnt           completed epochs
//   wd_err              watchdog expired, sticky (FEEDER_WATCHDOG_EN only)
module train_sample_feeder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned EPOCHS   = 100,
  parameter int unsigned WD_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_x1,
  input  logic [31:0]              wr_x2,
  input  logic [31:0]              wr_x3,
  input  logic [31:0]              wr_target,
  input  logic                     start,
  input  logic [2:0]               ctrl,
  output logic [31:0]              x1,
  output logic [31:0]              x2,
  output logic [31:0]              x3,
  output logic [31:0]              target_out,
  output logic                     set,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] sample_idx,
  output logic [15:0]              epoch_cnt
`ifdef FEEDER_WATCHDOG_EN
  ,
  output logic                     wd_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StInit, StPresent, StDone} state_e;

  state_e       state_q;
  logic [127:0] mem_q [DEPTH];
  logic [2:0]   ctrl_prev_q;
  logic         adv_q;

  logic         wrap_hit;
  logic         last_slot;
  logic         last_epoch;
  logic [127:0] cur_word;
  logic         wr_allowed;

  always_comb begin
    wrap_hit   = (ctrl_prev_q == 3'd7) && (ctrl == 3'd0);
    last_slot  = (sample_idx == AW'(DEPTH - 1));
    last_epoch = ((epoch_cnt + 16'd1) == 16'(EPOCHS));
    cur_word   = mem_q[sample_idx];
    wr_allowed = (state_q == StIdle) || (state_q == StDone);
  end

  // Sample storage has no reset; its contents are only meaningful once software has written them.
  always_ff @(posedge clk) begin
    if (wr_en && wr_allowed) begin
      mem_q[wr_addr] <= {wr_x1, wr_x2, wr_x3, wr_target};
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_LIMIT + 1);
  logic [WdW-1:0] wd_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctrl_prev_q <= 3'd0;
      adv_q       <= 1'b0;
      x1          <= 32'h0;
      x2          <= 32'h0;
      x3          <= 32'h0;
      target_out  <= 32'h0;
      set         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_idx  <= '0;
      epoch_cnt   <= 16'd0;
`ifdef FEEDER_WATCHDOG_EN
      wd_cnt_q    <= '0;
      wd_err      <= 1'b0;
`endif
    end else begin
      ctrl_prev_q <= ctrl;
      // A 7->0 wrap is registered first, and the slot advance happens on the edge after that.
      adv_q       <= (state_q == StPresent) && wrap_hit;
      set         <= 1'b0;

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StInit;
            set        <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            sample_idx <= '0;
            epoch_cnt  <= 16'd0;
            {x1, x2, x3, target_out} <= mem_q[0];
`ifdef FEEDER_WATCHDOG_EN
            wd_err     <= 1'b0;
`endif
          end
        end

        StInit: begin
          state_q <= StPresent;
          {x1, x2, x3, target_out} <= mem_q[0];
`ifdef FEEDER_WATCHDOG_EN
          wd_cnt_q <= '0;
`endif
        end

        StPresent: begin
          // Outputs follow the current slot, so they change one edge after sample_idx does.
          {x1, x2, x3, target_out} <= cur_word;
          if (adv_q) begin
            if (last_slot) begin
              sample_idx <= '0;
              epoch_cnt  <= epoch_cnt + 16'd1;
              if (last_epoch) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              sample_idx <= sample_idx + AW'(1);
            end
          end
`ifdef FEEDER_WATCHDOG_EN
          if (wrap_hit) begin
            wd_cnt_q <= '0;
          end else if (wd_cnt_q == WdW'(WD_LIMIT - 1)) begin
            // Stalled network: abort the run without claiming completion.
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b0;
            wd_err  <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule
